wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Schedules the single register-file write port among the four EXE/WB result slots: alu, ld, mul, div.
- Tracks which slots hold unwritten results.
- Drives the EXE/WB register's per-unit `wr_allow` enables and stalls a unit whose slot is still occupied.
- Grants one pending slot per cycle by round-robin, and preserves write-after-write order to the same Rd.

Parameters:
NUM_UNITS, 4, number of result slots; bit 3 = alu, 2 = ld, 1 = mul, 0 = div (fixed at 4).
DATA_W, 32, result width.
REG_W, 4, register-index width.

Ports:
clk  in  1  clock; all state updates on the falling edge, in step with the EXE/WB register.
rst  in  1  asynchronous, active-high reset.
exe_valid  in  4  unit i offers a result this cycle.
exe_rd  in  16  Rd of the offered result; unit i at [4i+3:4i].
wb_rd  in  16  Rd currently held in EXE/WB slot i, same packing.
wb_data  in  128  result held in EXE/WB slot i at [32i+31:32i].
wr_allow  out  4  load enable to the EXE/WB slots.
stall  out  4  unit i must hold its result.
rf_we  out  1  register-file write enable.
rf_waddr  out  4  register-file write address.
rf_wdata  out  32  register-file write data.
grant  out  4  one-hot; slot being written this cycle.
busy  out  1  any slot pending.

Behaviour:
- State:
  - `pending[3:0]`.
  - Age matrix `older[i][j]` (slot i older than slot j), 12 meaningful bits.
  - Round-robin pointer `rr[1:0]`.
- Reset, asynchronous: `pending` = 0, `older` = 0, `rr` = 3 (alu first). While `rst` = 1: `wr_allow`, `grant`, `stall`, `rf_we` and `busy` are forced to 0. `rf_waddr`/`rf_wdata` = 0.
- Eligibility:
  - `elig[i]` = `pending[i]` and no pending j != i with `wb_rd[j]` == `wb_rd[i]` and `older[j][i]`.
- Grant (combinational from state):
  - First eligible slot searching downward from `rr`, wrapping 0 -> 3.
  - At most one grant; none if `elig` = 0.
- Write port: `rf_we` = |`grant`; `rf_waddr`/`rf_wdata` = `wb_rd`/`wb_data` of the granted slot; 0 when no grant.
- Accept:
  - `wr_allow[i]` = `exe_valid[i]` and (!`pending[i]` or `grant[i]`).
  - A draining slot refills in the same cycle.
- Stall: `stall[i]` = `exe_valid[i]` and !`wr_allow[i]`.
- Falling edge updates:
  - `pending[i]` <= (`pending[i]` and !`grant[i]`) or `wr_allow[i]`.
  - On accept into slot i: `older[j][i]` <= 1 for every j remaining pending (pending and not granted); `older[i][j]` <= 0.
  - Simultaneous accepts are ordered by index, higher index older: alu > ld > mul > div.
  - On grant of slot i without refill: clear row and column i.
  - `rr` <= (granted index - 1) mod 4 when a grant occurs; unchanged otherwise.
- Latency: a result accepted at falling edge N may be written at the earliest during the following cycle (grant visible after edge N). Each pending slot waits at most 3 grant cycles absent Rd conflicts.
- Boundaries:
  - All four pending: only the granted slot may accept.
  - Same Rd in several slots: written strictly oldest-first.
  - Rd conflicts cannot deadlock, because the oldest of any Rd group is always eligible.
  - Reset mid-operation discards all pending results, with no register-file write.
- `busy` = |`pending`.

Optional Feature:
- Macro: `WB_PERF_EN`.
- When defined:
  - Adds output `stall_cnt` [31:0].
  - Reset value 0.
  - Increments on each falling edge where |`stall`; saturates at 32'hFFFF_FFFF.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. Single result: `exe_valid` = 4'b1000, `exe_rd[15:12]` = 5, `wb_data` alu = 32'h1234 -> next cycle `grant` = 4'b1000, `rf_we` = 1, `rf_waddr` = 5, `rf_wdata` = 32'h1234; then `busy` = 0.
2. Round-robin: all four accepted together with distinct Rd 1..4 -> grants over the next 4 cycles are 1000, 0100, 0010, 0001; no stalls.
3. WAW: div accepted with Rd = 7 at edge N, alu accepted with Rd = 7 at edge N+1, `rr` favouring alu -> div written before alu; final write to r7 is alu's data.
4. Backpressure: alu pending and mul granted while `exe_valid` = 4'b1010 -> `wr_allow` = 4'b0010, `stall` = 4'b1000; alu accepted in the cycle it is granted.
5. Reset mid-operation: 3 slots pending, assert `rst` between edges -> `pending`, `busy`, `rf_we`, `wr_allow` = 0 immediately; after release, first grant goes to alu.
6. With `WB_PERF_EN`: hold all slots full with `exe_valid` = 4'hF for 10 cycles -> `stall_cnt` = 10; force the counter to 32'hFFFF_FFFF -> stays saturated.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port among the four EXE/WB result
//   slots (bit 3 = alu, 2 = ld, 1 = mul, 0 = div). Tracks which slots hold
//   unwritten results, grants one eligible slot per cycle round-robin, keeps
//   write-after-write order per Rd with an age matrix, and drives the EXE/WB
//   slot load enables / unit stalls. State moves on the falling clock edge,
//   in step with the EXE/WB register.
//
// Ports
//   clk        clock (state updates on negedge)
//   rst        asynchronous active-high reset
//   exe_valid  unit i offers a result this cycle
//   exe_rd     offered Rd per unit, unit i at [4i+3:4i]
//   wb_rd      Rd held in EXE/WB slot i, same packing
//   wb_data    result held in EXE/WB slot i at [32i+31:32i]
//   wr_allow   EXE/WB slot load enables
//   stall      unit i must hold its result
//   rf_we/rf_waddr/rf_wdata  register-file write port
//   grant      one-hot slot being written this cycle
//   busy       any slot pending
//   stall_cnt  (only with WB_PERF_EN) saturating count of stalled cycles
//
// Optional feature macro: WB_PERF_EN
module wb_port_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_UNITS-1:0]          exe_valid,
  input  logic [NUM_UNITS*REG_W-1:0]    exe_rd,
  input  logic [NUM_UNITS*REG_W-1:0]    wb_rd,
  input  logic [NUM_UNITS*DATA_W-1:0]   wb_data,
  output logic [NUM_UNITS-1:0]          wr_allow,
  output logic [NUM_UNITS-1:0]          stall,
  output logic                          rf_we,
  output logic [REG_W-1:0]              rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic [NUM_UNITS-1:0]          grant,
  output logic                          busy
`ifdef WB_PERF_EN
  ,
  output logic [31:0]                   stall_cnt
`endif
);

  logic [NUM_UNITS-1:0][REG_W-1:0]     rd_a;
  logic [NUM_UNITS-1:0][DATA_W-1:0]    dat_a;
  assign rd_a  = wb_rd;
  assign dat_a = wb_data;

  logic [NUM_UNITS-1:0]                pending_q, pending_d;
  // older_q[i][j]: slot i holds an older result than slot j
  logic [NUM_UNITS-1:0][NUM_UNITS-1:0] older_q, older_d;
  logic [1:0]                          rr_q, rr_d;

  logic [NUM_UNITS-1:0] blk, elig, gnt, acc, remain;
  logic [1:0]           gidx, srch;
  logic                 found;

  // A slot is blocked while an older pending slot targets the same Rd.
  always_comb begin
    blk  = '0;
    elig = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      for (int j = 0; j < NUM_UNITS; j++) begin
        if (j != i && pending_q[j] && rd_a[j] == rd_a[i] && older_q[j][i])
          blk[i] = 1'b1;
      end
      elig[i] = pending_q[i] & ~blk[i];
    end
  end

  // Downward search from rr_q, wrapping 0 -> 3.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    srch  = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      srch = rr_q - 2'(k);
      if (!found && elig[srch]) begin
        gnt[srch] = 1'b1;
        gidx      = srch;
        found     = 1'b1;
      end
    end
  end

  // A draining slot may refill in the same cycle.
  assign acc    = exe_valid & (~pending_q | gnt);
  assign remain = pending_q & ~gnt;

  always_comb begin
    pending_d = remain | acc;
    rr_d      = found ? gidx - 2'd1 : rr_q;
    older_d   = older_q;
    for (int i = 0; i < NUM_UNITS; i++) begin
      for (int j = 0; j < NUM_UNITS; j++) begin
        if (i == j)
          older_d[i][j] = 1'b0;
        else if (acc[j])
          // Everything still waiting is older than a new arrival; among
          // simultaneous arrivals the higher index counts as older.
          older_d[i][j] = remain[i] | (acc[i] & (i > j));
        else if (acc[i])
          older_d[i][j] = 1'b0;
        else if (gnt[i] | gnt[j])
          older_d[i][j] = 1'b0;
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      older_q   <= '0;
      rr_q      <= 2'd3;
    end else begin
      pending_q <= pending_d;
      older_q   <= older_d;
      rr_q      <= rr_d;
    end
  end

  // Outputs are held quiet for the whole time reset is asserted.
  assign grant    = rst ? '0 : gnt;
  assign wr_allow = rst ? '0 : acc;
  assign stall    = rst ? '0 : (exe_valid & ~acc);
  assign rf_we    = ~rst & found;
  assign rf_waddr = (~rst & found) ? rd_a[gidx]  : '0;
  assign rf_wdata = (~rst & found) ? dat_a[gidx] : '0;
  assign busy     = ~rst & (|pending_q);

`ifdef WB_PERF_EN
  logic [31:0] stall_cnt_q;
  always_ff @(negedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if ((|stall) && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign stall_cnt = stall_cnt_q;
`endif

  // The offered Rd is latched by the EXE/WB register itself, and the age
  // matrix diagonal is meaningless; neither feeds any logic here.
  logic unused_sink;
  assign unused_sink = ^exe_rd ^ older_q[0][0] ^ older_q[1][1]
                     ^ older_q[2][2] ^ older_q[3][3];

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   exe_valid = '0;
  logic [15:0]  exe_rd = '0;
  logic [15:0]  wb_rd = '0;
  logic [127:0] wb_data = '0;
  logic [3:0]   wr_allow, stall, grant;
  logic         rf_we, busy;
  logic [3:0]   rf_waddr;
  logic [31:0]  rf_wdata;
`ifdef WB_PERF_EN
  logic [31:0]  stall_cnt;
`endif

  wb_port_arbiter dut (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_rd(exe_rd),
    .wb_rd(wb_rd), .wb_data(wb_data), .wr_allow(wr_allow), .stall(stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .grant(grant), .busy(busy)
`ifdef WB_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: each pending slot carries an arrival ticket; the
  // smallest ticket among slots sharing an Rd is the one allowed to write.
  logic [3:0]  mp;
  logic [3:0]  mrd  [4];
  logic [31:0] mdat [4];
  int          mst  [4];
  int          mrr;
  int          seq;
  logic [31:0] last_r7;
  logic [3:0]  obs_wa, obs_st, obs_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_wb();
    for (int i = 0; i < 4; i++) begin
      wb_rd[4*i +: 4]    = mrd[i];
      wb_data[32*i +: 32] = mdat[i];
    end
  endtask

  // Called just after a falling edge; applies inputs, checks mid-cycle,
  // then advances the model and the EXE/WB register across the next edge.
  task automatic cycle(input logic [3:0] v, input logic [15:0] rd, input logic [127:0] d);
    logic [3:0] el, eg, ewa;
    int gi, idx;
    exe_valid = v;
    exe_rd    = rd;
    @(posedge clk);
    el = '0;
    for (int i = 0; i < 4; i++) begin
      if (mp[i]) begin
        el[i] = 1'b1;
        for (int j = 0; j < 4; j++)
          if (j != i && mp[j] && mrd[j] == mrd[i] && mst[j] < mst[i]) el[i] = 1'b0;
      end
    end
    eg = '0;
    gi = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (mrr - k + 4) % 4;
      if (gi < 0 && el[idx]) begin
        gi = idx;
        eg[idx] = 1'b1;
      end
    end
    ewa = v & (~mp | eg);
    chk("grant", grant, eg);
    chk("wr_allow", wr_allow, ewa);
    chk("stall", stall, v & ~ewa);
    chk("rf_we", rf_we, gi >= 0);
    chk("rf_waddr", rf_waddr, (gi >= 0) ? mrd[gi] : 4'd0);
    chk("rf_wdata", rf_wdata, (gi >= 0) ? mdat[gi] : 32'd0);
    chk("busy", busy, |mp);
    obs_wa = wr_allow;
    obs_st = stall;
    obs_g  = grant;
    if (rf_we && rf_waddr == 4'd7) last_r7 = rf_wdata;
    @(negedge clk);
    #1;
    mp = (mp & ~eg) | ewa;
    for (int i = 3; i >= 0; i--) begin
      if (ewa[i]) begin
        mst[i]  = seq;
        seq++;
        mrd[i]  = rd[4*i +: 4];
        mdat[i] = d[32*i +: 32];
      end
    end
    if (gi >= 0) mrr = (gi + 3) % 4;
    drive_wb();
  endtask

  task automatic do_reset();
    exe_valid = 4'hF;
    rst = 1'b1;
    #1;
    chk("rst_grant", grant, 4'd0);
    chk("rst_wr_allow", wr_allow, 4'd0);
    chk("rst_stall", stall, 4'd0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_waddr", rf_waddr, 4'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    exe_valid = '0;
    mp  = '0;
    mrr = 3;
  endtask

  initial begin
    mp = '0; mrr = 3; seq = 0; last_r7 = '0;
    for (int i = 0; i < 4; i++) begin
      mrd[i] = '0; mdat[i] = '0; mst[i] = 0;
    end

    // Reset state
    do_reset();

    // Single result from alu
    cycle(4'b1000, 16'h5000, {32'h0000_1234, 96'h0});
    cycle(4'b0000, 16'h0, 128'h0);
    chk("t1_grant", obs_g, 4'b1000);
    cycle(4'b0000, 16'h0, 128'h0);

    // Round-robin over four simultaneous results
    do_reset();
    cycle(4'b1111, 16'h4321, {32'hA4, 32'hA3, 32'hA2, 32'hA1});
    cycle(4'b0000, 16'h0, 128'h0); chk("t2_g0", obs_g, 4'b1000);
    cycle(4'b0000, 16'h0, 128'h0); chk("t2_g1", obs_g, 4'b0100);
    cycle(4'b0000, 16'h0, 128'h0); chk("t2_g2", obs_g, 4'b0010);
    cycle(4'b0000, 16'h0, 128'h0); chk("t2_g3", obs_g, 4'b0001);

    // WAW on r7: div then alu
    do_reset();
    cycle(4'b0111, 16'h0127, {32'h0, 32'hB1, 32'hB2, 32'hD1D1_0007});
    cycle(4'b1000, 16'h7000, {32'hA1A1_0007, 96'h0});
    for (int n = 0; n < 5; n++) cycle(4'b0000, 16'h0, 128'h0);
    chk("t3_last_r7", last_r7, 32'hA1A1_0007);

    // Backpressure: alu pending while mul is granted
    do_reset();
    cycle(4'b0100, 16'h0300, {32'h0, 32'hC3, 64'h0});
    cycle(4'b1010, 16'h1020, {32'hC1, 32'h0, 32'hC2, 32'h0});
    cycle(4'b1010, 16'h4050, {32'hC4, 32'h0, 32'hC5, 32'h0});
    chk("t4_wa", obs_wa, 4'b0010);
    chk("t4_stall", obs_st, 4'b1000);
    cycle(4'b1000, 16'h6000, {32'hC6, 96'h0});
    chk("t4_alu_refill", obs_wa, 4'b1000);
    for (int n = 0; n < 4; n++) cycle(4'b0000, 16'h0, 128'h0);

    // Reset mid-operation, then all four accepted: alu first
    cycle(4'b1110, 16'h1230, {32'hE1, 32'hE2, 32'hE3, 32'h0});
    do_reset();
    cycle(4'b1111, 16'h9876, {32'hF1, 32'hF2, 32'hF3, 32'hF4});
    cycle(4'b0000, 16'h0, 128'h0);
    chk("t5_first", obs_g, 4'b1000);
    for (int n = 0; n < 3; n++) cycle(4'b0000, 16'h0, 128'h0);

    // Random traffic with a small Rd space to force conflicts
    for (int n = 0; n < 400; n++) begin
      logic [15:0]  r;
      logic [127:0] d;
      r = '0;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 3));
      d = {$urandom, $urandom, $urandom, $urandom};
      cycle(4'($urandom), r, d);
      if (n == 200) do_reset();
    end

`ifdef WB_PERF_EN
    do_reset();
    cycle(4'hF, 16'h1234, {32'h1, 32'h2, 32'h3, 32'h4});
    for (int n = 0; n < 10; n++) cycle(4'hF, 16'h5678, {32'h5, 32'h6, 32'h7, 32'h8});
    chk("t6_stall_cnt", stall_cnt, 32'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
